// File: rtl/dcsk_demodulator_if.sv
// Chip-stream input and recovered-message output bundle for the DCSK demodulator.
// The master drives the chip stream; the slave (demodulator) returns the message.
interface dcsk_demodulator_if #(
   parameter int unsigned MSG_WIDTH = 4
);
   logic                 chip_valid;
   logic                 rx_chip;
   logic                 start;
   logic [MSG_WIDTH-1:0] message;
   logic                 msg_valid;
   logic                 busy;

   modport master (output chip_valid, rx_chip, start,
                   input  message, msg_valid, busy);
   modport slave  (input  chip_valid, rx_chip, start,
                   output message, msg_valid, busy);
endinterface

// File: rtl/dcsk_demodulator.sv
// DCSK demodulator: correlates each symbol's data chips against its stored reference
// chips, majority-decides each bit (ties decide 1) and publishes the full frame message.
module dcsk_demodulator #(
   parameter int unsigned MSG_WIDTH = 4,
   parameter int unsigned DELAY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   dcsk_demodulator_if.slave bus
);
   localparam int unsigned CW = $clog2(DELAY);
   localparam int unsigned MW = $clog2(DELAY + 1);
   localparam int unsigned SW = $clog2(MSG_WIDTH);
   localparam int unsigned DW = MW + 1;

   typedef enum logic [1:0] {IDLE, REF, DATA} state_t;

   state_t               r_state,     w_state_nxt;
   logic [CW-1:0]        r_chip_cnt,  w_chip_cnt_nxt;
   logic [MW-1:0]        r_match_cnt, w_match_cnt_nxt;
   logic [SW-1:0]        r_sym_cnt,   w_sym_cnt_nxt;
   logic [DELAY-1:0]     r_ref,       w_ref_nxt;
   logic [MSG_WIDTH-1:0] r_shift,     w_shift_nxt;
   logic [MSG_WIDTH-1:0] r_message,   w_message_nxt;
   logic                 r_msg_valid, w_msg_valid_nxt;
   logic                 r_busy,      w_busy_nxt;

   logic                 w_last_chip;
   logic                 w_last_sym;
   logic                 w_eq;
   logic                 w_bit;
   logic [MW-1:0]        w_match_inc;

   // Next-state and datapath decode; nothing advances without chip_valid.
   always_comb begin
      w_state_nxt     = r_state;
      w_chip_cnt_nxt  = r_chip_cnt;
      w_match_cnt_nxt = r_match_cnt;
      w_sym_cnt_nxt   = r_sym_cnt;
      w_ref_nxt       = r_ref;
      w_shift_nxt     = r_shift;
      w_message_nxt   = r_message;
      w_msg_valid_nxt = 1'b0;

      w_last_chip = (r_chip_cnt == CW'(DELAY - 1));
      w_last_sym  = (r_sym_cnt == SW'(MSG_WIDTH - 1));
      w_eq        = (bus.rx_chip == r_ref[r_chip_cnt]);
      w_match_inc = r_match_cnt + MW'(w_eq);
      w_bit       = ({w_match_inc, 1'b0} >= DW'(DELAY));

      if (bus.chip_valid) begin
         // The final data chip of a frame always completes it, even with start set.
         if (bus.start && !(r_state == DATA && w_last_chip && w_last_sym)) begin
            w_ref_nxt[0]    = bus.rx_chip;
            w_chip_cnt_nxt  = CW'(1);
            w_match_cnt_nxt = '0;
            w_sym_cnt_nxt   = '0;
            w_shift_nxt     = '0;
            w_state_nxt     = REF;
         end else begin
            case (r_state)
               REF: begin
                  w_ref_nxt[r_chip_cnt] = bus.rx_chip;
                  if (w_last_chip) begin
                     w_chip_cnt_nxt  = '0;
                     w_match_cnt_nxt = '0;
                     w_state_nxt     = DATA;
                  end else begin
                     w_chip_cnt_nxt = r_chip_cnt + CW'(1);
                  end
               end
               DATA: begin
                  if (w_last_chip) begin
                     w_shift_nxt     = {r_shift[MSG_WIDTH-2:0], w_bit};
                     w_chip_cnt_nxt  = '0;
                     w_match_cnt_nxt = '0;
                     if (w_last_sym) begin
                        w_message_nxt   = {r_shift[MSG_WIDTH-2:0], w_bit};
                        w_msg_valid_nxt = 1'b1;
                        w_sym_cnt_nxt   = '0;
                        w_state_nxt     = IDLE;
                     end else begin
                        w_sym_cnt_nxt = r_sym_cnt + SW'(1);
                        w_state_nxt   = REF;
                     end
                  end else begin
                     w_chip_cnt_nxt  = r_chip_cnt + CW'(1);
                     w_match_cnt_nxt = w_match_inc;
                  end
               end
               default: ;
            endcase
         end
      end

      w_busy_nxt = (w_state_nxt != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_chip_cnt  <= '0;
         r_match_cnt <= '0;
         r_sym_cnt   <= '0;
         r_ref       <= '0;
         r_shift     <= '0;
         r_message   <= '0;
         r_msg_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_chip_cnt  <= w_chip_cnt_nxt;
         r_match_cnt <= w_match_cnt_nxt;
         r_sym_cnt   <= w_sym_cnt_nxt;
         r_ref       <= w_ref_nxt;
         r_shift     <= w_shift_nxt;
         r_message   <= w_message_nxt;
         r_msg_valid <= w_msg_valid_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign bus.message   = r_message;
   assign bus.msg_valid = r_msg_valid;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_dcsk_demodulator.sv
// Self-checking bench for dcsk_demodulator: directed frames plus randomized frames
// checked against a symbol-correlation reference model.
module tb_dcsk_demodulator;
   localparam int unsigned MW = 4;
   localparam int unsigned D  = 2;
   localparam int unsigned FL = 2 * D * MW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcsk_demodulator_if #(.MSG_WIDTH(MW)) bus ();
   dcsk_demodulator #(.MSG_WIDTH(MW), .DELAY(D)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_vec   = 0;
   int n_err   = 0;
   int n_pulse = 0;

   // Counts every cycle msg_valid is high, so a stretched pulse shows up as extra.
   always @(negedge clk) if (bus.msg_valid === 1'b1) n_pulse++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   // Reference: per symbol, count reference/data chip agreements; bit = 2*hits >= D.
   function automatic logic [MW-1:0] model_msg(input logic [FL-1:0] ch);
      logic [MW-1:0] m;
      int            hits;
      m = '0;
      for (int s = 0; s < int'(MW); s++) begin
         hits = 0;
         for (int k = 0; k < int'(D); k++)
            if (ch[FL-1-(s*2*D+k)] == ch[FL-1-(s*2*D+D+k)]) hits++;
         m = {m[MW-2:0], (2 * hits >= int'(D))};
      end
      return m;
   endfunction

   function automatic logic [FL-1:0] build_frame(input logic [MW-1:0] msg, input int noise);
      logic [FL-1:0] ch;
      logic          r;
      logic          dc;
      ch = '0;
      for (int s = 0; s < int'(MW); s++)
         for (int k = 0; k < int'(D); k++) begin
            r  = 1'($urandom_range(0, 1));
            dc = msg[MW-1-s] ? r : ~r;
            if (int'($urandom_range(0, 99)) < noise) dc = ~dc;
            ch[FL-1-(s*2*D+k)]   = r;
            ch[FL-1-(s*2*D+D+k)] = dc;
         end
      return ch;
   endfunction

   task automatic send_chip(input logic c, input logic s, input int gap);
      @(negedge clk);
      bus.chip_valid = 1'b1;
      bus.rx_chip    = c;
      bus.start      = s;
      @(posedge clk);
      #1;
      if (gap > 0) begin
         bus.chip_valid = 1'b0;
         bus.start      = 1'($urandom_range(0, 1));
         bus.rx_chip    = 1'($urandom_range(0, 1));
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [FL-1:0] ch, input int gap, input int n);
      for (int i = 0; i < n; i++) send_chip(ch[FL-1-i], (i == 0), gap);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.chip_valid = 1'b0;
      bus.start      = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.chip_valid = 1'b0;
      bus.start      = 1'b0;
      bus.rx_chip    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (bus.message !== '0) begin n_err++; $display("FAIL reset_message: got %b expected %b", bus.message, 4'b0); end
      n_vec++; if (bus.msg_valid !== 1'b0) begin n_err++; $display("FAIL reset_msg_valid: got %b expected 0", bus.msg_valid); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [FL-1:0] fr;
      fr = 16'b1111_1100_1111_1111;
      for (int i = 0; i < int'(FL); i++) begin
         send_chip(fr[FL-1-i], (i == 0), 0);
         n_vec++;
         if (i < int'(FL) - 1) begin
            if (bus.busy !== 1'b1 || bus.msg_valid !== 1'b0 || bus.message !== '0) begin
               n_err++;
               $display("FAIL basic_mid chip %0d: got busy=%b valid=%b msg=%b expected busy=1 valid=0 msg=0000",
                        i + 1, bus.busy, bus.msg_valid, bus.message);
            end
         end else begin
            if (bus.msg_valid !== 1'b1 || bus.busy !== 1'b0) begin
               n_err++;
               $display("FAIL basic_end: got valid=%b busy=%b expected valid=1 busy=0", bus.msg_valid, bus.busy);
            end
         end
      end
      n_vec++; if (bus.message !== 4'b1011) begin n_err++; $display("FAIL basic_message: got %b expected 1011", bus.message); end
      idle(1);
      n_vec++; if (bus.msg_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse_width: got %b expected 0", bus.msg_valid); end
   endtask

   task automatic test_chaos();
      logic [FL-1:0] fr;
      int            p0;
      fr = 16'b1001_1010_1010_1001;
      p0 = n_pulse;
      send_frame(fr, 0, FL);
      n_vec++; if (bus.msg_valid !== 1'b1) begin n_err++; $display("FAIL chaos_valid: got %b expected 1", bus.msg_valid); end
      n_vec++; if (bus.message !== 4'b0110) begin n_err++; $display("FAIL chaos_message: got %b expected 0110", bus.message); end
      idle(2);
      n_vec++; if (n_pulse - p0 != 1) begin n_err++; $display("FAIL chaos_pulses: got %0d expected 1", n_pulse - p0); end
   endtask

   task automatic test_gaps();
      logic [FL-1:0] fr;
      int            p0;
      fr = 16'b1111_1100_1111_1111;
      p0 = n_pulse;
      send_frame(fr, 3, FL);
      idle(1);
      n_vec++; if (bus.message !== 4'b1011) begin n_err++; $display("FAIL gaps_message: got %b expected 1011", bus.message); end
      n_vec++; if (n_pulse - p0 != 1) begin n_err++; $display("FAIL gaps_pulses: got %0d expected 1", n_pulse - p0); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL gaps_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_tie();
      logic [FL-1:0] fr;
      int            p0;
      fr = 16'b1110_1110_1110_1110;
      p0 = n_pulse;
      send_frame(fr, 0, FL);
      n_vec++; if (bus.message !== 4'b1111) begin n_err++; $display("FAIL tie_message: got %b expected 1111", bus.message); end
      idle(2);
      n_vec++; if (n_pulse - p0 != 1) begin n_err++; $display("FAIL tie_pulses: got %0d expected 1", n_pulse - p0); end
   endtask

   task automatic test_abort();
      logic [FL-1:0] junk;
      logic [FL-1:0] fr;
      int            p0;
      junk = build_frame(4'($urandom), 0);
      fr   = 16'b1111_1100_1111_1111;
      p0   = n_pulse;
      send_frame(junk, 0, 6);
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL abort_busy: got %b expected 1", bus.busy); end
      send_frame(fr, 0, FL);
      idle(2);
      n_vec++; if (bus.message !== 4'b1011) begin n_err++; $display("FAIL abort_message: got %b expected 1011", bus.message); end
      n_vec++; if (n_pulse - p0 != 1) begin n_err++; $display("FAIL abort_pulses: got %0d expected 1", n_pulse - p0); end
   endtask

   task automatic test_reset_mid();
      logic [FL-1:0] fr1;
      logic [FL-1:0] fr2;
      int            p0;
      fr1 = 16'b1111_1100_1111_1111;
      fr2 = 16'b1001_1010_1010_1001;
      p0  = n_pulse;
      send_frame(fr1, 0, 8);
      @(negedge clk);
      bus.chip_valid = 1'b1;
      bus.rx_chip    = fr1[FL-1-8];
      bus.start      = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_vec++; if (bus.busy !== 1'b0 || bus.message !== '0 || bus.msg_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_async: got busy=%b msg=%b valid=%b expected busy=0 msg=0000 valid=0",
                  bus.busy, bus.message, bus.msg_valid);
      end
      @(negedge clk) rst = 1'b0;
      send_chip(1'b1, 1'b0, 0);
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_wait_idle: got busy=%b expected 0", bus.busy); end
      send_frame(fr2, 0, FL - 1);
      n_vec++; if (bus.message !== '0 || bus.busy !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_hold: got msg=%b busy=%b expected msg=0000 busy=1", bus.message, bus.busy);
      end
      send_chip(fr2[0], 1'b0, 0);
      n_vec++; if (bus.msg_valid !== 1'b1 || bus.message !== 4'b0110) begin
         n_err++;
         $display("FAIL rstmid_message: got valid=%b msg=%b expected valid=1 msg=0110", bus.msg_valid, bus.message);
      end
      idle(2);
      n_vec++; if (n_pulse - p0 != 1) begin n_err++; $display("FAIL rstmid_pulses: got %0d expected 1", n_pulse - p0); end
   endtask

   task automatic test_back_to_back();
      logic [FL-1:0] fa;
      logic [FL-1:0] fb;
      int            p0;
      fa = build_frame(4'($urandom), 30);
      fb = build_frame(4'($urandom), 30);
      p0 = n_pulse;
      send_frame(fa, 0, FL - 1);
      send_chip(fa[0], 1'b1, 0);
      n_vec++; if (bus.msg_valid !== 1'b1 || bus.busy !== 1'b0 || bus.message !== model_msg(fa)) begin
         n_err++;
         $display("FAIL b2b_first: got valid=%b busy=%b msg=%b expected valid=1 busy=0 msg=%b",
                  bus.msg_valid, bus.busy, bus.message, model_msg(fa));
      end
      send_frame(fb, 0, FL);
      n_vec++; if (bus.msg_valid !== 1'b1 || bus.message !== model_msg(fb)) begin
         n_err++;
         $display("FAIL b2b_second: got valid=%b msg=%b expected valid=1 msg=%b",
                  bus.msg_valid, bus.message, model_msg(fb));
      end
      idle(2);
      n_vec++; if (n_pulse - p0 != 2) begin n_err++; $display("FAIL b2b_pulses: got %0d expected 2", n_pulse - p0); end
   endtask

   task automatic test_random();
      logic [FL-1:0] fr;
      logic [MW-1:0] exp;
      int            p0;
      for (int t = 0; t < 16; t++) begin
         fr  = build_frame(4'($urandom), 25);
         exp = model_msg(fr);
         p0  = n_pulse;
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) send_chip(1'($urandom_range(0, 1)), 1'b0, 0);
         for (int i = 0; i < int'(FL); i++) send_chip(fr[FL-1-i], (i == 0), int'($urandom_range(0, 2)));
         idle(3);
         n_vec++; if (bus.message !== exp) begin n_err++; $display("FAIL random_message frame %0d: got %b expected %b", t, bus.message, exp); end
         n_vec++; if (n_pulse - p0 != 1) begin n_err++; $display("FAIL random_pulses frame %0d: got %0d expected 1", t, n_pulse - p0); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_chaos();
      test_gaps();
      test_tie();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/dcsk_demodulator.md
DCSK_DEMODULATOR -- requirements
Module: dcsk_demodulator

Interface
REQ-001 Parameter MSG_WIDTH, default 4, number of message bits per frame (>=2).
REQ-002 Parameter DELAY, default 2, chips per half-symbol, i.e. reference length (>=2).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 chip_valid  input  1  rx_chip is a valid chip this cycle.
REQ-007 rx_chip  input  1  received DCSK chip stream (modulator output).
REQ-008 start  input  1  qualified by chip_valid; marks rx_chip as first reference chip of a frame.
REQ-009 message  output  MSG_WIDTH  last recovered message, MSB = first transmitted bit.
REQ-010 msg_valid  output  1  one-cycle pulse, message updated.
REQ-011 busy  output  1  frame reception in progress.

Function
REQ-012 Frame format: MSG_WIDTH symbols, MSB first; each symbol = DELAY reference chips, then DELAY data chips; data chip = reference chip for bit 1, inverted for bit 0.
REQ-013 Chips SHALL be consumed only on edges where chip_valid=1; chip_valid=0 cycles freeze all state and counters.
REQ-014 FSM states: IDLE, REF, DATA.
REQ-015 IDLE: accepted chip with start=1 -> stored as reference chip 0, go REF (or DATA if DELAY reached); accepted chips without start ignored.
REQ-016 REF: store each accepted chip in a DELAY-deep reference register at index chip_cnt; after DELAY-th chip -> DATA, chip_cnt cleared, match_cnt cleared.
REQ-017 DATA: compare each accepted chip with reference[chip_cnt]; increment match_cnt on equality (width clog2(DELAY+1), no overflow possible).
REQ-018 Decision on DELAY-th data chip: bit = 1 if 2*match_cnt_final >= DELAY, else 0 (tie decides 1); bit shifted into internal shift register LSB side.
REQ-019 After a non-final symbol -> REF; after symbol MSG_WIDTH -> IDLE.
REQ-020 On the edge accepting the final data chip, message SHALL load the complete MSG_WIDTH-bit result and msg_valid SHALL be high for exactly the following cycle; latency 0 chips after last chip.
REQ-021 message SHALL hold its value until the next completed frame; aborted frames never update message.
REQ-022 busy = 1 in REF and DATA, 0 in IDLE.
REQ-023 start=1 with chip_valid=1 while busy SHALL abort the current frame, discard partial bits, and treat the chip as reference chip 0 of a new frame (no msg_valid for the aborted frame).
REQ-024 start=1 on the same edge as the final data chip of a frame: final chip is data (frame completes, msg_valid pulses), start ignored; start is honoured only when the chip is a reference-chip-0 candidate (IDLE) or an abort as REQ-023 elsewhere.
REQ-025 start with chip_valid=0 SHALL be ignored.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, all counters, reference register, shift register and message to 0, msg_valid=0, busy=0.
REQ-027 rst asserted mid-frame SHALL discard the frame; after release the block waits in IDLE for start.

Verification (MSG_WIDTH=4, DELAY=2, chip_valid=1 unless stated)
REQ-028 start with chips 11 11 | 11 00 | 11 11 | 11 11 -> msg_valid pulse after chip 16, message=4'b1011, busy high chips 1-16.
REQ-029 Chaos chips 10 per reference, message 0110: stream 10 01 | 10 10 | 10 10 | 10 01 -> message=4'b0110.
REQ-030 Tie: reference 11, data 10 in every symbol -> match_cnt=1 each symbol -> message=4'b1111.
REQ-031 chip_valid low for 3 cycles after every chip of REQ-028 stream -> same message 4'b1011, msg_valid one cycle, no extra pulses.
REQ-032 start re-asserted at chip 7 of a frame, then full 1011 frame from there -> exactly one msg_valid, message=4'b1011.
REQ-033 rst pulsed at chip 9, then REQ-029 frame -> message 0 until frame ends, then 4'b0110; no pulse for the interrupted frame.
